sw_core: RTL and testbench

Parametrised stopwatch core for the stopwatch design. It replaces the fixed-rate stopwatch counter with configurable clock and count rates, a configurable minute range, and a per-field adjust mode. It adds a lap/split freeze and a rollover pulse, and drives the display path with MIN:SEC values.

---
 rtl/sw_if.sv | 26 ++
 rtl/sw_core.sv | 143 ++++++++++++++
 tb/tb_sw_core.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_if.sv
// sw_if: stopwatch control and display bundle.
// master drives the raw controls, slave drives the display/status.
interface sw_if #(
    parameter int MIN_W = 7
);
    logic             PAUSE;
    logic             ADJ;
    logic             SEL;
    logic             LAP;
    logic [MIN_W-1:0] MIN;
    logic [5:0]       SEC;
    logic             RUNNING;
    logic             ADJ_ACTIVE;
    logic             LAP_VALID;
    logic             ROLLOVER;

    modport master (
        output PAUSE, ADJ, SEL, LAP,
        input  MIN, SEC, RUNNING, ADJ_ACTIVE, LAP_VALID, ROLLOVER
    );

    modport slave (
        input  PAUSE, ADJ, SEL, LAP,
        output MIN, SEC, RUNNING, ADJ_ACTIVE, LAP_VALID, ROLLOVER
    );
endinterface

// File: rtl/sw_core.sv
// sw_core: parametrised MIN:SEC stopwatch with run/hold/adjust modes,
// lap freeze and a rollover pulse.
module sw_core #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int COUNT_HZ = 1,
    parameter int ADJ_HZ   = 2,
    parameter int MIN_MAX  = 99,
    parameter int MIN_W    = 7
) (
    input logic clk,
    input logic RESET_N,
    sw_if.slave bus
);
    localparam int CNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam int CW = $clog2(CNT_DIV);
    localparam int AW = $clog2(ADJ_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST = AW'(ADJ_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);

    // bit order: {LAP, SEL, ADJ, PAUSE}
    logic [3:0] s1, s2;
    logic pause_d, lap_d;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] adiv, adiv_nxt;
    logic [MIN_W-1:0] live_min, min_nxt;
    logic [5:0] live_sec, sec_nxt;
    logic [MIN_W-1:0] lap_min, lap_min_nxt;
    logic [5:0] lap_sec, lap_sec_nxt;
    logic running, run_nxt;
    logic lap_valid, lapv_nxt;
    logic roll, roll_nxt;

    logic pause_p, lap_p;
    logic adj_on, sel_on, run_on, hold_on;
    logic sec_last, min_last;

    assign pause_p  = s2[0] & ~pause_d;
    assign lap_p    = s2[3] & ~lap_d;
    assign adj_on   = s2[1];
    assign sel_on   = s2[2];
    assign run_on   = ~adj_on & running;
    assign hold_on  = ~adj_on & ~running;
    assign sec_last = (live_sec == 6'd59);
    assign min_last = (live_min == MIN_TOP);

    always_comb begin
        cnt_nxt     = cnt;
        adiv_nxt    = '0;
        min_nxt     = live_min;
        sec_nxt     = live_sec;
        lap_min_nxt = lap_min;
        lap_sec_nxt = lap_sec;
        lapv_nxt    = lap_valid;
        roll_nxt    = 1'b0;
        run_nxt     = running ^ pause_p;

        unique case (1'b1)
            adj_on: begin
                adiv_nxt = adiv + AW'(1);
                if (adiv == ADJ_LAST) begin
                    adiv_nxt = '0;
                    if (sel_on)
                        sec_nxt = sec_last ? 6'd0 : live_sec + 6'd1;
                    else
                        min_nxt = min_last ? '0 : live_min + MIN_W'(1);
                end
            end
            run_on: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (!sec_last) begin
                        sec_nxt = live_sec + 6'd1;
                    end else begin
                        sec_nxt = 6'd0;
                        if (min_last) begin
                            min_nxt  = '0;
                            roll_nxt = 1'b1;
                        end else begin
                            min_nxt = live_min + MIN_W'(1);
                        end
                    end
                end
            end
            hold_on: begin
                cnt_nxt = cnt;
            end
        endcase

        // lap snapshot takes the value before this cycle's increment
        if (lap_p) begin
            if (lap_valid) begin
                lapv_nxt = 1'b0;
            end else begin
                lapv_nxt    = 1'b1;
                lap_min_nxt = live_min;
                lap_sec_nxt = live_sec;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            s1        <= '0;
            s2        <= '0;
            pause_d   <= 1'b0;
            lap_d     <= 1'b0;
            cnt       <= '0;
            adiv      <= '0;
            live_min  <= '0;
            live_sec  <= '0;
            lap_min   <= '0;
            lap_sec   <= '0;
            running   <= 1'b1;
            lap_valid <= 1'b0;
            roll      <= 1'b0;
        end else begin
            s1        <= {bus.LAP, bus.SEL, bus.ADJ, bus.PAUSE};
            s2        <= s1;
            pause_d   <= s2[0];
            lap_d     <= s2[3];
            cnt       <= cnt_nxt;
            adiv      <= adiv_nxt;
            live_min  <= min_nxt;
            live_sec  <= sec_nxt;
            lap_min   <= lap_min_nxt;
            lap_sec   <= lap_sec_nxt;
            running   <= run_nxt;
            lap_valid <= lapv_nxt;
            roll      <= roll_nxt;
        end
    end

    assign bus.MIN        = lap_valid ? lap_min : live_min;
    assign bus.SEC        = lap_valid ? lap_sec : live_sec;
    assign bus.RUNNING    = running;
    assign bus.ADJ_ACTIVE = s2[1];
    assign bus.LAP_VALID  = lap_valid;
    assign bus.ROLLOVER   = roll;
endmodule

// File: tb/tb_sw_core.sv
// tb_sw_core: vector table, corner sequences and a randomized run
// checked against a total-seconds reference model.
module tb_sw_core;
    localparam int CLK_HZ   = 20;
    localparam int COUNT_HZ = 1;
    localparam int ADJ_HZ   = 2;
    localparam int MIN_MAX  = 2;
    localparam int MIN_W    = 7;
    localparam int CNT_DIV  = CLK_HZ / COUNT_HZ;
    localparam int ADJ_DIV  = CLK_HZ / ADJ_HZ;
    localparam int NSEC     = (MIN_MAX + 1) * 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit chk_en = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    sw_if #(.MIN_W(MIN_W)) bus ();

    sw_core #(
        .CLK_HZ(CLK_HZ), .COUNT_HZ(COUNT_HZ), .ADJ_HZ(ADJ_HZ),
        .MIN_MAX(MIN_MAX), .MIN_W(MIN_W)
    ) dut (
        .clk(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: time kept as total seconds; raw inputs seen
    // through a delay line of past samples
    logic [2:0] hp, ha, hs, hl;
    int m_tot, m_lap, m_ph, m_aph;
    bit m_run, m_lapv, m_roll, m_adj;

    always @(posedge clk or negedge rst_n) begin : mdl
        bit a, s, pp, lp;
        int mm, ss;
        if (!rst_n) begin
            hp = '0; ha = '0; hs = '0; hl = '0;
            m_tot = 0; m_lap = 0; m_ph = 0; m_aph = 0;
            m_run = 1; m_lapv = 0; m_roll = 0; m_adj = 0;
        end else begin
            a  = ha[1];
            s  = hs[1];
            pp = hp[1] & ~hp[2];
            lp = hl[1] & ~hl[2];
            m_roll = 0;
            if (lp) begin
                if (m_lapv) m_lapv = 0;
                else begin
                    m_lapv = 1;
                    m_lap = m_tot;
                end
            end
            if (a) begin
                m_aph++;
                if (m_aph == ADJ_DIV) begin
                    m_aph = 0;
                    mm = m_tot / 60;
                    ss = m_tot % 60;
                    if (s) ss = (ss + 1) % 60;
                    else mm = (mm + 1) % (MIN_MAX + 1);
                    m_tot = mm * 60 + ss;
                end
            end else begin
                m_aph = 0;
                if (m_run) begin
                    m_ph++;
                    if (m_ph == CNT_DIV) begin
                        m_ph = 0;
                        m_tot = (m_tot + 1) % NSEC;
                        m_roll = (m_tot == 0);
                    end
                end
            end
            if (pp) m_run = !m_run;
            hp = {hp[1:0], bus.PAUSE};
            ha = {ha[1:0], bus.ADJ};
            hs = {hs[1:0], bus.SEL};
            hl = {hl[1:0], bus.LAP};
            m_adj = ha[1];
        end
    end

    always @(negedge clk) begin : cmp
        int shown;
        logic [MIN_W-1:0] em;
        logic [5:0] es;
        if (chk_en && rst_n) begin
            shown = m_lapv ? m_lap : m_tot;
            em = MIN_W'(shown / 60);
            es = 6'(shown % 60);
            n_chk++;
            if (bus.MIN === em && bus.SEC === es &&
                bus.RUNNING === m_run && bus.ADJ_ACTIVE === m_adj &&
                bus.LAP_VALID === m_lapv && bus.ROLLOVER === m_roll)
                n_pass++;
            else
                $display("FAIL model t=%0t got %0d:%0d r%b a%b l%b o%b required %0d:%0d r%b a%b l%b o%b",
                         $time, bus.MIN, bus.SEC, bus.RUNNING, bus.ADJ_ACTIVE,
                         bus.LAP_VALID, bus.ROLLOVER, em, es, m_run, m_adj,
                         m_lapv, m_roll);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0d required %0d", name, act, exp);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".min"}, 32'(bus.MIN), 0);
        chk({tag, ".sec"}, 32'(bus.SEC), 0);
        chk({tag, ".run"}, 32'(bus.RUNNING), 1);
        chk({tag, ".adj"}, 32'(bus.ADJ_ACTIVE), 0);
        chk({tag, ".lapv"}, 32'(bus.LAP_VALID), 0);
        chk({tag, ".roll"}, 32'(bus.ROLLOVER), 0);
    endtask

    typedef struct {
        bit p, a, s, l;
        int cyc;
        int emin, esec;
        bit erun, eadj, elapv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pulses;
        tbl.push_back(vec_t'{0,0,0,0,    0, 0, 0, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,   19, 0, 0, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,    1, 0, 1, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,   80, 0, 5, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,    4, 0, 5, 1,0,0});
        tbl.push_back(vec_t'{1,0,0,0,    3, 0, 5, 0,0,0});
        tbl.push_back(vec_t'{0,0,0,0,  100, 0, 5, 0,0,0});
        tbl.push_back(vec_t'{1,0,0,0,    3, 0, 5, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,   12, 0, 5, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,    1, 0, 6, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0, 1040, 0,58, 1,0,0});
        tbl.push_back(vec_t'{0,1,1,0,    2, 0,58, 1,1,0});
        tbl.push_back(vec_t'{0,1,1,0,   10, 0,59, 1,1,0});
        tbl.push_back(vec_t'{0,1,1,0,   10, 0, 0, 1,1,0});
        tbl.push_back(vec_t'{0,1,1,0,   10, 0, 1, 1,1,0});
        tbl.push_back(vec_t'{0,1,0,0,   10, 1, 1, 1,1,0});
        tbl.push_back(vec_t'{0,1,0,0,   10, 2, 1, 1,1,0});
        tbl.push_back(vec_t'{0,1,0,0,   10, 0, 1, 1,1,0});
        tbl.push_back(vec_t'{0,0,0,0,    2, 0, 1, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,   17, 0, 1, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,    1, 0, 2, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0, 1377, 1,10, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,1,    3, 1,10, 1,0,1});
        tbl.push_back(vec_t'{0,0,0,0,  290, 1,10, 1,0,1});
        tbl.push_back(vec_t'{0,0,0,1,    3, 1,25, 1,0,0});
        tbl.push_back(vec_t'{0,0,0,0,    7, 1,26, 1,0,0});

        bus.PAUSE = 0; bus.ADJ = 0; bus.SEL = 0; bus.LAP = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst_n = 1;
        chk_en = 1;

        foreach (tbl[i]) begin
            bus.PAUSE = tbl[i].p;
            bus.ADJ   = tbl[i].a;
            bus.SEL   = tbl[i].s;
            bus.LAP   = tbl[i].l;
            repeat (tbl[i].cyc) @(negedge clk);
            chk($sformatf("vec%0d.min", i), 32'(bus.MIN), tbl[i].emin);
            chk($sformatf("vec%0d.sec", i), 32'(bus.SEC), tbl[i].esec);
            chk($sformatf("vec%0d.run", i), 32'(bus.RUNNING), 32'(tbl[i].erun));
            chk($sformatf("vec%0d.adj", i), 32'(bus.ADJ_ACTIVE), 32'(tbl[i].eadj));
            chk($sformatf("vec%0d.lapv", i), 32'(bus.LAP_VALID), 32'(tbl[i].elapv));
        end

        // asynchronous reset while adjusting with the lap frozen
        bus.ADJ = 1; bus.SEL = 1; bus.LAP = 1;
        repeat (3) @(negedge clk);
        bus.LAP = 0;
        repeat (15) @(negedge clk);
        chk("pre_rst.lapv", 32'(bus.LAP_VALID), 1);
        chk("pre_rst.adj", 32'(bus.ADJ_ACTIVE), 1);
        #2 rst_n = 0;
        #1 chk_reset_vals("async_rst");
        bus.ADJ = 0; bus.SEL = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;

        // full-range run up to the rollover
        pulses = 0;
        repeat (CNT_DIV * NSEC - 1) begin
            @(negedge clk);
            if (bus.ROLLOVER === 1'b1) pulses++;
        end
        chk("pre_roll.min", 32'(bus.MIN), MIN_MAX);
        chk("pre_roll.sec", 32'(bus.SEC), 59);
        chk("early_roll_pulses", pulses, 0);
        @(negedge clk);
        chk("roll.pulse", 32'(bus.ROLLOVER), 1);
        chk("roll.min", 32'(bus.MIN), 0);
        chk("roll.sec", 32'(bus.SEC), 0);
        @(negedge clk);
        chk("roll.clear", 32'(bus.ROLLOVER), 0);

        // randomized controls against the model
        repeat (60) begin
            bus.ADJ   = ($urandom_range(0, 3) == 0);
            bus.SEL   = 1'($urandom_range(0, 1));
            bus.PAUSE = ($urandom_range(0, 4) == 0);
            bus.LAP   = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            bus.PAUSE = 0;
            bus.LAP   = 0;
            repeat ($urandom_range(1, 80)) @(negedge clk);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
